// File: rtl/frame_write_sequencer_if.sv
// Byte-stream input and pixel/address strobe outputs of frame_write_sequencer.
// Handshake: valid-only streams with no ready. A byte is consumed in every cycle
// its valid is high. Each output strobe is a single-cycle qualifier for its data.
interface frame_write_sequencer_if;
  logic        byte_axiiv;
  logic [7:0]  byte_axiid;
  logic        byte_last;
  logic        addr_axiov;
  logic [23:0] addr_axiod;
  logic        pixel_axiov;
  logic [7:0]  pixel_axiod;
  logic        buf_sel;
  logic        frame_done;
  logic        pkt_err;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output byte_axiiv, byte_axiid, byte_last,
    input  addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    input  buf_sel, frame_done, pkt_err, busy, dbg_state
  );

  modport slave (
    input  byte_axiiv, byte_axiid, byte_last,
    output addr_axiov, addr_axiod, pixel_axiov, pixel_axiod,
    output buf_sel, frame_done, pkt_err, busy, dbg_state
  );
endinterface

// File: rtl/frame_write_sequencer.sv
// Splits a packetised byte stream into a start-address strobe and pixel strobes,
// validating the length and address range and handling end-of-frame marker packets.
module frame_write_sequencer #(
  parameter int          PKT_PIXELS   = 256,
  parameter int          ADDR_MAX     = 76799,
  parameter logic [23:0] FRAME_MARKER = 24'hFFFFFF
) (
  input logic                    clk,
  input logic                    rst_n,
  frame_write_sequencer_if.slave bus
);
  localparam int              PCW      = $clog2(PKT_PIXELS + 1);
  localparam logic [24:0]     ADDR_LIM = 25'(ADDR_MAX - PKT_PIXELS + 1);
  localparam logic [PCW-1:0]  PIX_LAST = PCW'(PKT_PIXELS - 1);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PIX  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t         state_q;
  logic [1:0]     hdr_cnt_q;
  logic [15:0]    hdr_q;
  logic [PCW-1:0] pix_cnt_q;
  logic           ovl_q;
  logic           addr_v_q;
  logic [23:0]    addr_q;
  logic           pix_v_q;
  logic [7:0]     pix_q;
  logic           buf_sel_q;
  logic           frame_done_q;
  logic           pkt_err_q;

  logic [23:0]    hdr_full;
  logic           hdr_is_marker;
  logic           hdr_out_of_range;
  logic           pix_final;

  // Header byte 2 is still on the input, so the full address is assembled combinationally.
  assign hdr_full         = {hdr_q, bus.byte_axiid};
  assign hdr_is_marker    = (hdr_full == FRAME_MARKER);
  assign hdr_out_of_range = ({1'b0, hdr_full} > ADDR_LIM);
  assign pix_final        = (pix_cnt_q == PIX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      hdr_cnt_q    <= 2'd0;
      hdr_q        <= 16'h0;
      pix_cnt_q    <= '0;
      ovl_q        <= 1'b0;
      addr_v_q     <= 1'b0;
      addr_q       <= 24'h0;
      pix_v_q      <= 1'b0;
      pix_q        <= 8'h0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      addr_v_q     <= 1'b0;
      pix_v_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pkt_err_q    <= 1'b0;
      if (bus.byte_axiiv) begin
        unique case (state_q)
          S_HDR: begin
            if (hdr_cnt_q != 2'd2) begin
              hdr_q <= {hdr_q[7:0], bus.byte_axiid};
              if (bus.byte_last) begin
                pkt_err_q <= 1'b1;
                hdr_cnt_q <= 2'd0;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + 2'd1;
              end
            end else begin
              hdr_cnt_q <= 2'd0;
              if (hdr_is_marker) begin
                buf_sel_q    <= ~buf_sel_q;
                frame_done_q <= 1'b1;
                if (!bus.byte_last) state_q <= S_DROP;
              end else if (hdr_out_of_range) begin
                pkt_err_q <= 1'b1;
                if (!bus.byte_last) state_q <= S_DROP;
              end else if (bus.byte_last) begin
                pkt_err_q <= 1'b1;
              end else begin
                addr_v_q  <= 1'b1;
                addr_q    <= hdr_full;
                pix_cnt_q <= '0;
                state_q   <= S_PIX;
              end
            end
          end
          S_PIX: begin
            pix_v_q   <= 1'b1;
            pix_q     <= bus.byte_axiid;
            pix_cnt_q <= pix_cnt_q + PCW'(1);
            if (bus.byte_last) begin
              state_q <= S_HDR;
              if (!pix_final) pkt_err_q <= 1'b1;
            end else if (pix_final) begin
              state_q <= S_DROP;
              ovl_q   <= 1'b1;
            end
          end
          S_DROP: begin
            // An overlong packet reports its error on the first surplus byte only.
            if (ovl_q) begin
              pkt_err_q <= 1'b1;
              ovl_q     <= 1'b0;
            end
            if (bus.byte_last) state_q <= S_HDR;
          end
          default: state_q <= S_HDR;
        endcase
      end
    end
  end

  assign bus.addr_axiov  = addr_v_q;
  assign bus.addr_axiod  = addr_q;
  assign bus.pixel_axiov = pix_v_q;
  assign bus.pixel_axiod = pix_q;
  assign bus.buf_sel     = buf_sel_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pkt_err     = pkt_err_q;
  assign bus.busy        = (state_q != S_HDR) || (hdr_cnt_q != 2'd0);
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_frame_write_sequencer.sv
// Randomised packet bench for frame_write_sequencer with a packet-level reference
// model feeding an expected-event queue that a negedge monitor drains.
module tb_frame_write_sequencer;
  localparam int PIX      = 4;
  localparam int AMAX     = 76799;
  localparam int LIM      = AMAX - PIX + 1;
  localparam int EW       = 60;
  localparam logic [3:0] K_ADDR = 4'd1;
  localparam logic [3:0] K_PIX  = 4'd2;
  localparam logic [3:0] K_FD   = 4'd3;
  localparam logic [3:0] K_ERR  = 4'd4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic model_buf;
  logic [7:0]    pkt[$];
  logic [EW-1:0] exp_q[$];

  frame_write_sequencer_if dut_if ();

  frame_write_sequencer #(
    .PKT_PIXELS  (PIX),
    .ADDR_MAX    (AMAX),
    .FRAME_MARKER(24'hFFFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  task automatic push_evt(input logic [3:0] kind, input logic [23:0] data, input int at);
    exp_q.push_back({kind, data, 32'(at)});
  endtask

  task automatic check_evt(input string name, input logic [3:0] kind, input logic [23:0] data);
    logic [EW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected strobe data=%h at cycle %0d, expected no event", name, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e[59:56] != kind || e[55:32] != data || e[31:0] != 32'(cyc)) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                 name, kind, data, cyc, e[59:56], e[55:32], e[31:0]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut_if.addr_axiov)  check_evt("addr",  K_ADDR, dut_if.addr_axiod);
      if (dut_if.pixel_axiov) check_evt("pixel", K_PIX,  {16'h0, dut_if.pixel_axiod});
      if (dut_if.frame_done)  check_evt("frame_done", K_FD, {23'h0, dut_if.buf_sel});
      if (dut_if.pkt_err)     check_evt("pkt_err", K_ERR, 24'h0);
    end
  end

  // Reference model: classifies a whole packet; sc[i] is the cycle byte i is sampled.
  task automatic predict(input int sc[$]);
    int n;
    int npix;
    int nfwd;
    logic [23:0] hdr;
    n = pkt.size();
    if (n < 3) begin
      push_evt(K_ERR, 24'h0, sc[n-1]);
    end else begin
      hdr = {pkt[0], pkt[1], pkt[2]};
      if (hdr == 24'hFFFFFF) begin
        model_buf = ~model_buf;
        push_evt(K_FD, {23'h0, model_buf}, sc[2]);
      end else if (int'(hdr) > LIM || n == 3) begin
        push_evt(K_ERR, 24'h0, sc[2]);
      end else begin
        push_evt(K_ADDR, hdr, sc[2]);
        npix = n - 3;
        nfwd = (npix < PIX) ? npix : PIX;
        for (int k = 0; k < nfwd; k++) push_evt(K_PIX, {16'h0, pkt[3+k]}, sc[3+k]);
        if (npix < PIX)      push_evt(K_ERR, 24'h0, sc[n-1]);
        else if (npix > PIX) push_evt(K_ERR, 24'h0, sc[3+PIX]);
      end
    end
  endtask

  // Driver: called just after a posedge; each byte is sampled on a later posedge.
  task automatic drive_byte(input logic [7:0] b, input logic last);
    dut_if.byte_axiiv = 1'b1;
    dut_if.byte_axiid = b;
    dut_if.byte_last  = last;
    @(posedge clk);
    #1;
    dut_if.byte_axiiv = 1'b0;
    dut_if.byte_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    dut_if.byte_axiiv = 1'b0;
    dut_if.byte_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt();
    int sc[$];
    int g[$];
    int t;
    int n;
    n = pkt.size();
    t = cyc;
    for (int i = 0; i < n; i++) begin
      int gi;
      gi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      g.push_back(gi);
      t = t + gi + 1;
      sc.push_back(t);
    end
    predict(sc);
    for (int i = 0; i < n; i++) begin
      idle(g[i]);
      drive_byte(pkt[i], (i == n - 1));
    end
  endtask

  task automatic build(input logic [23:0] hdr, input int len);
    logic [7:0] hb[3];
    hb[0] = hdr[23:16];
    hb[1] = hdr[15:8];
    hb[2] = hdr[7:0];
    pkt = {};
    for (int i = 0; i < len; i++)
      pkt.push_back((i < 3) ? hb[i] : 8'($urandom_range(0, 255)));
  endtask

  // Stimulus
  initial begin
    logic [23:0] h;
    int r;
    cyc = 0;
    checks = 0;
    errors = 0;
    model_buf = 1'b0;
    rst_n = 1'b0;
    dut_if.byte_axiiv = 1'b0;
    dut_if.byte_axiid = 8'h0;
    dut_if.byte_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset addr_axiov",  {31'h0, dut_if.addr_axiov},  32'h0);
    chk("reset pixel_axiov", {31'h0, dut_if.pixel_axiov}, 32'h0);
    chk("reset buf_sel",     {31'h0, dut_if.buf_sel},     32'h0);
    chk("reset pkt_err",     {31'h0, dut_if.pkt_err},     32'h0);
    chk("reset busy",        {31'h0, dut_if.busy},        32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pkt = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_pkt();
    pkt = '{8'hFF, 8'hFF, 8'hFF};
    send_pkt();
    send_pkt();
    idle(2);
    chk("buf_sel after two markers", {31'h0, dut_if.buf_sel}, 32'h0);
    pkt = '{8'h01, 8'h2B, 8'hFD, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt();
    build(24'h000200, 3 + PIX);
    send_pkt();
    pkt = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h22};
    send_pkt();
    build(24'h000300, 3 + 6);
    send_pkt();
    build(24'h000040, 3 + PIX);
    send_pkt();
    build(24'(LIM), 3 + PIX);
    send_pkt();
    build(24'(LIM + 1), 3 + PIX);
    send_pkt();
    build(24'h000050, 1);
    send_pkt();
    build(24'h000050, 2);
    send_pkt();
    build(24'h000050, 3);
    send_pkt();
    build(24'hFFFFFF, 6);
    send_pkt();
    idle(3);

    // Asynchronous reset in the middle of a header
    drive_byte(8'h00, 1'b0);
    drive_byte(8'h01, 1'b0);
    chk("busy mid header", {31'h0, dut_if.busy}, 32'h1);
    chk("buf_sel before reset", {31'h0, dut_if.buf_sel}, 32'h1);
    #2;
    rst_n = 1'b0;
    model_buf = 1'b0;
    #1;
    chk("async reset busy",    {31'h0, dut_if.busy},    32'h0);
    chk("async reset buf_sel", {31'h0, dut_if.buf_sel}, 32'h0);
    chk("async reset state",   {30'h0, dut_if.dbg_state}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{8'h00, 8'h00, 8'h08, 8'h31, 8'h32, 8'h33, 8'h34};
    send_pkt();

    for (int p = 0; p < 200; p++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       h = 24'hFFFFFF;
        1:       h = 24'(LIM);
        2:       h = 24'(LIM + 1);
        3:       h = 24'($urandom_range(LIM + 1, 24'hFFFFFE));
        default: h = 24'($urandom_range(0, LIM));
      endcase
      build(h, $urandom_range(1, PIX + 6));
      send_pkt();
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("expected queue drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_write_sequencer.md
Name: frame_write_sequencer

Overview:
- Parses the raw byte stream from the receive path into the address and pixel strobes that frame_packager consumes.
- Sits between the byte receiver and frame_packager. frame_packager writes pixels into the frame BRAM.
- Per packet: checks length and address bounds, then forwards the address and pixels.
- Handles frame-end marker packets by toggling a ping-pong buffer select and pulsing frame_done.

Parameters:
PKT_PIXELS, 256, number of pixel bytes in every data packet (>=1).
ADDR_MAX, 76799, highest legal pixel address (320x240 frame, fits 17 bits).
FRAME_MARKER, 24'hFFFFFF, header address value that denotes end-of-frame.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
byte_axiiv  in  1  input byte valid
byte_axiid  in  8  input byte
byte_last  in  1  qualifies byte_axiiv; marks the final byte of a packet
addr_axiov  out  1  one-cycle strobe; packet start address valid
addr_axiod  out  24  packet start address, forwarded as received
pixel_axiov  out  1  pixel byte valid
pixel_axiod  out  8  pixel byte
buf_sel  out  1  active write buffer (ping-pong); toggles on frame marker
frame_done  out  1  one-cycle pulse after a frame marker is accepted
pkt_err  out  1  one-cycle pulse on any malformed packet
busy  out  1  high whenever state != S_HDR or hdr_cnt != 0

Behaviour:
- Reset (async assert, sync release): all outputs 0. buf_sel=0, state S_HDR, hdr_cnt=0, pix_cnt=0.
- All outputs are registered. Response appears 1 cycle after the accepting input byte.
- No backpressure: every byte with byte_axiiv=1 is consumed in its cycle.
- S_HDR:
  - Collect 3 bytes MSB first into hdr[23:0]; hdr_cnt counts 0..2.
  - byte_last on header byte 0 or 1: pkt_err, hdr_cnt<=0, stay in S_HDR.
  - On byte 2, if hdr==FRAME_MARKER:
    - buf_sel toggles and frame_done pulses, both next cycle.
    - byte_last on this byte -> stay in S_HDR; otherwise -> S_DROP (no error).
  - On byte 2, if hdr > ADDR_MAX-PKT_PIXELS+1 (compare in 25-bit unsigned):
    - pkt_err next cycle.
    - byte_last on this byte -> S_HDR; otherwise -> S_DROP.
  - On byte 2, if byte_last is set on a valid-address header: pkt_err, stay in S_HDR, no addr_axiov.
  - Otherwise addr_axiov=1 and addr_axiod=hdr next cycle; go to S_PIX with pix_cnt=0.
- S_PIX:
  - Each input byte gives pixel_axiov=1 and pixel_axiod=byte next cycle; pix_cnt++.
  - A pixel arriving the cycle after header byte 2 is legal. Output order is still addr_axiov, then pixel.
  - byte_last with pix_cnt+1 == PKT_PIXELS: clean end, go to S_HDR.
  - byte_last with pix_cnt+1 < PKT_PIXELS (short packet): that byte is still forwarded; pkt_err; go to S_HDR.
  - Byte number PKT_PIXELS without byte_last: forwarded; go to S_DROP and flag an overlong packet.
- S_DROP:
  - Bytes are discarded; pixel_axiov and addr_axiov stay 0.
  - byte_last -> S_HDR.
  - If S_DROP was entered as overlong, pkt_err pulses on the next dropped byte (only once per packet).
- Counters: pix_cnt width $clog2(PKT_PIXELS+1); no wrap within a legal packet.
- buf_sel wraps 1->0 freely.
- frame_done and pkt_err never assert together.
- Reset mid-packet: immediate return to the reset state. The partial packet is discarded. The next byte after rst_n deasserts is treated as header byte 0.

Test Plan:
- PKT_PIXELS=4. Send bytes 00,01,00,AA,BB,CC,DD(last) -> addr_axiov with addr_axiod=24'h000100, then pixel_axiov x4 carrying AA,BB,CC,DD, each one cycle after its input; no pkt_err.
- Send FF,FF,FF(last) twice -> frame_done pulses twice; buf_sel goes 0->1->0; no pixel or addr strobes.
- Header 01,2B,FD with ADDR_MAX=76799, PKT_PIXELS=4 (76797+3=76800 > max) -> pkt_err once; the 4 following pixels are dropped until byte_last; the next valid packet is forwarded normally.
- Short packet 00,00,10,11,22(last) -> addr 24'h000010, pixels 11,22 forwarded, pkt_err pulses 1 cycle after 22, state returns to S_HDR.
- Overlong packet with 6 pixels, byte_last on 6th -> 4 pixels forwarded, pkt_err once, bytes 5–6 dropped; the following packet parses correctly.
- Assert rst_n=0 after header byte 1 -> all outputs 0 asynchronously; after release, bytes 00,00,08,... parse as a fresh header yielding addr 24'h000008.
